id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register of the 5-stage MIPS pipeline, with load-use hazard detection and register-file write-bypass. It captures decoded operands, register specifiers and control from the ID stage and presents them to EX, the forwarding unit and the ALU operand muxes. It inserts a bubble on load-use hazards or branch flush and stalls PC and IF/ID. It also corrects operands read in the same cycle that WB writes them.

## Interface
- DATA_W, 32, operand/immediate width
- REG_AW, 4, register specifier width (16 registers, r0 hard-wired zero)
- ALUOP_W, 4, ALU operation code width
- CNT_W, 16, stall performance counter width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  REG_AW  decoded specifiers
- id_uses_rt  in  1  instruction reads rt as a source (R-type, store, beq)
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  in  1 each  control
- id_alu_op  in  ALUOP_W  ALU control
- flush  in  1  branch/jump taken in EX; kill the instruction in ID
- wb_reg_write  in  1, wb_rd  in  REG_AW, wb_data  in  DATA_W  WB-stage write port
- ex_valid  out  1; ex_rs, ex_rt, ex_rd  out  REG_AW; ex_rs_data, ex_rt_data, ex_imm  out  DATA_W
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst  out  1; ex_alu_op  out  ALUOP_W
- stall  out  1  load-use hazard detected (combinational)
- pc_write, if_id_write  out  1  = ~stall
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Hazard: stall = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- Each rising edge selects one of three actions:
  - Flush (priority over stall): load a bubble.
  - Stall: load a bubble. IF/ID and PC hold through pc_write/if_id_write = 0.
  - Otherwise: load the ID inputs, ex_valid <= id_valid.
- Bubble: ex_valid, all control bits, ex_alu_op, ex_rs, ex_rt and ex_rd are 0. Data fields are don't-care, driven to 0.
  - Zero specifiers guarantee the forwarding unit never matches a bubble.
- Load of an instruction with id_valid = 0: treated as a bubble.
- WB bypass, applied on a normal load:
  - If wb_reg_write & (wb_rd != 0) & (wb_rd == id_rs), ex_rs_data <= wb_data; same rule for rt.
  - r0 is never bypassed.
- stall_cnt increments on every edge where stall = 1 and flush = 0. It saturates at all-ones.

## Timing
- All ex_* outputs and stall_cnt are registered. They update on the rising clk edge one cycle after ID presents inputs (latency 1).
- stall, pc_write and if_id_write are combinational from current ex_* registers and id_* inputs, valid in the same cycle.
- Load-use costs exactly one bubble. On the next cycle ex_mem_read = 0 in the bubble, so stall deasserts and the held instruction issues. MEM/WB forwarding then supplies the load data.
- Simultaneous flush and stall: bubble loaded, stall_cnt not incremented. stall still deasserts pc_write; the branch-target PC update is owned by the PC mux and overrides it.
- Back-to-back loads to the same consumer: each produces its own single stall.
- Reset (asynchronous, any time, including mid-stall): all ex_* outputs 0, ex_valid 0, stall 0, pc_write/if_id_write 1, stall_cnt 0. First edge after rst_n rises performs a normal load.

## Structure
- Shared package mips_pipe_pkg:
  - REG_AW, DATA_W and ALUOP_W constants.
  - ALU op code constants.
  - Localparam for the bubble control value, reused by EX/MEM and MEM/WB registers.
- One sub-module, hazard_detect: purely combinational load-use comparator producing stall. Pipeline register, bypass and counter stay in id_ex_stage.

## Test plan
- Plain issue: id_rs=2, id_rt=3, id_rs_data=0x11, id_reg_write=1, no hazard -> next edge ex_rs=2, ex_rs_data=0x11, ex_reg_write=1, ex_valid=1, stall=0.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 -> stall=1, pc_write=0; next edge ex_valid=0, all control 0. Following cycle stall=0 and the instruction issues. stall_cnt=1.
- id_uses_rt=0 with ex_rt=5 == id_rt=5 and ex_mem_read=1 -> stall=0. Same with ex_rt=0 -> stall=0.
- Flush with simultaneous hazard -> bubble loaded, stall_cnt unchanged, ex_rd=0.
- WB bypass: wb_reg_write=1, wb_rd=7, wb_data=0xABCD, id_rt=7, id_rt_data=0x1 -> ex_rt_data=0xABCD. wb_rd=0 case -> no bypass.
- Assert rst_n=0 mid-stall -> outputs clear immediately without a clock edge. Force stall for 2^CNT_W+3 cycles -> stall_cnt holds all-ones.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared widths, ALU op codes and control-bundle types for the MIPS pipeline registers.
package mips_pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 4;
  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'h1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'h2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'h3;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 4'h4;
  localparam logic [ALUOP_W-1:0] ALU_NOR = 4'h5;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'h6;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'h7;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'h8;
  localparam logic [ALUOP_W-1:0] ALU_LUI = 4'h9;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  // All-zero control: a bubble never writes registers or touches memory.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination is read by the instruction in ID.
module hazard_detect #(
  parameter int REG_AW = mips_pipe_pkg::REG_AW
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              stall
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (ex_rt == id_rs);
  assign w_rt_match = id_uses_rt & (ex_rt == id_rt);

  // r0 loads never create a dependency since r0 always reads zero.
  assign stall = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, WB write-bypass and stall counter.
module id_ex_stage #(
  parameter int DATA_W  = mips_pipe_pkg::DATA_W,
  parameter int REG_AW  = mips_pipe_pkg::REG_AW,
  parameter int ALUOP_W = mips_pipe_pkg::ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_uses_rt,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               flush,
  input  logic               wb_reg_write,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               ex_valid,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               stall,
  output logic               pc_write,
  output logic               if_id_write,
  output logic [CNT_W-1:0]   stall_cnt
);

  import mips_pipe_pkg::ctrl_t;
  import mips_pipe_pkg::CTRL_BUBBLE;

  ctrl_t               r_ctrl;
  logic                r_valid;
  logic [REG_AW-1:0]   r_rs;
  logic [REG_AW-1:0]   r_rt;
  logic [REG_AW-1:0]   r_rd;
  logic [DATA_W-1:0]   r_rs_data;
  logic [DATA_W-1:0]   r_rt_data;
  logic [DATA_W-1:0]   r_imm;
  logic [ALUOP_W-1:0]  r_alu_op;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_stall;
  logic                w_load;
  logic                w_byp_rs;
  logic                w_byp_rt;
  ctrl_t               w_id_ctrl;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid    (r_valid),
    .ex_mem_read (r_ctrl.mem_read),
    .ex_rt       (r_rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .stall       (w_stall)
  );

  assign w_load    = id_valid & ~flush & ~w_stall;
  // The register file returns stale data when WB writes the same register this cycle.
  assign w_byp_rs  = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs);
  assign w_byp_rt  = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rt);
  assign w_id_ctrl = '{reg_write:  id_reg_write,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       mem_to_reg: id_mem_to_reg,
                       alu_src:    id_alu_src,
                       reg_dst:    id_reg_dst};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_ctrl      <= CTRL_BUBBLE;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_alu_op    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_valid <= w_load;
      if (w_load) begin
        r_ctrl    <= w_id_ctrl;
        r_rs      <= id_rs;
        r_rt      <= id_rt;
        r_rd      <= id_rd;
        r_rs_data <= w_byp_rs ? wb_data : id_rs_data;
        r_rt_data <= w_byp_rt ? wb_data : id_rt_data;
        r_imm     <= id_imm;
        r_alu_op  <= id_alu_op;
      end else begin
        // Zero specifiers keep the forwarding unit from matching a bubble.
        r_ctrl    <= CTRL_BUBBLE;
        r_rs      <= '0;
        r_rt      <= '0;
        r_rd      <= '0;
        r_rs_data <= '0;
        r_rt_data <= '0;
        r_imm     <= '0;
        r_alu_op  <= '0;
      end
      if (w_stall && !flush && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_rs_data    = r_rs_data;
  assign ex_rt_data    = r_rt_data;
  assign ex_imm        = r_imm;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_reg_dst    = r_ctrl.reg_dst;
  assign ex_alu_op     = r_alu_op;
  assign stall         = w_stall;
  assign pc_write      = ~w_stall;
  assign if_id_write   = ~w_stall;
  assign stall_cnt     = r_stall_cnt;

endmodule
